// File: rtl/ifc_array_accum.sv
// Lockstep multi-channel accumulator behind a single-stage valid/ready pipe.
// Each accepted beat updates per-channel X/Y state and registers an 8-bit result Z.
module ifc_array_accum #(
   parameter int unsigned NCH    = 2,
   parameter int unsigned W      = 8,
   parameter int unsigned AW     = 16,
   parameter int unsigned X_INIT = 17,
   parameter int unsigned Y_INIT = 21
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CLR,
   input  logic         MODE,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [W-1:0] A [NCH],
   input  logic [W-1:0] B [NCH],
   input  logic [W-1:0] Q [NCH],
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [W-1:0] Z [NCH],
   output logic [15:0]  BEATS
);

   logic [AW-1:0] x_q [NCH];
   logic [AW-1:0] y_q [NCH];
   logic [AW-1:0] x_d [NCH];
   logic [AW-1:0] y_d [NCH];
   logic [W-1:0]  z_q [NCH];
   logic [W-1:0]  z_d [NCH];
   logic          out_valid_q;
   logic [15:0]   beats_q;
   logic          in_ready;
   logic          accept;
   logic          consume;

   // Downstream slot is free or being drained this cycle; CLR blocks intake.
   assign in_ready = !CLR && (!out_valid_q || OUT_READY);
   assign accept   = IN_VALID && in_ready;
   assign consume  = out_valid_q && OUT_READY;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         x_d[i] = MODE ? (x_q[i] + AW'(Q[i])) : (x_q[i] - AW'(Q[i]));
         y_d[i] = y_q[i] + AW'(1);
         // Result uses pre-update X/Y; only the low W bits are kept.
         z_d[i] = W'(AW'(A[i] | B[i]) | (x_q[i] + y_q[i] - AW'(Q[i])));
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NCH; i++) begin
            x_q[i] <= AW'(X_INIT);
            y_q[i] <= AW'(Y_INIT);
            z_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         beats_q     <= '0;
      end else if (CLR) begin
         for (int i = 0; i < NCH; i++) begin
            x_q[i] <= AW'(X_INIT);
            y_q[i] <= AW'(Y_INIT);
            z_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         beats_q     <= '0;
      end else if (accept) begin
         for (int i = 0; i < NCH; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
            z_q[i] <= z_d[i];
         end
         out_valid_q <= 1'b1;
         beats_q     <= beats_q + 16'd1;
      end else if (consume) begin
         out_valid_q <= 1'b0;
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = out_valid_q;
   assign BEATS     = beats_q;
   assign Z         = z_q;

endmodule

// File: tb/tb_ifc_array_accum.sv
// Self-checking bench for ifc_array_accum: directed scenarios plus randomized traffic
// checked against an arithmetic model of the accumulate rules.
module tb_ifc_array_accum;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr, mode, in_valid, out_ready;
   logic       in_ready, out_valid;
   logic [7:0] a_s [2];
   logic [7:0] b_s [2];
   logic [7:0] q_s [2];
   logic [7:0] z_s [2];
   logic [15:0] beats;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int unsigned mx [2];
   int unsigned my [2];
   logic [7:0]  mz [2];
   bit          mv;
   int unsigned mb;
   bit          obs_rdy, exp_rdy;

   ifc_array_accum dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .CLR      (clr),
      .MODE     (mode),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .A        (a_s),
      .B        (b_s),
      .Q        (q_s),
      .OUT_VALID(out_valid),
      .OUT_READY(out_ready),
      .Z        (z_s),
      .BEATS    (beats)
   );

   always #5 clk = ~clk;

   task automatic model_init();
      for (int c = 0; c < 2; c++) begin
         mx[c] = 17;
         my[c] = 21;
         mz[c] = 8'h00;
      end
      mv = 1'b0;
      mb = 0;
   endtask

   task automatic set_ops(input logic [7:0] a0, b0, q0, a1, b1, q1);
      a_s[0] = a0; b_s[0] = b0; q_s[0] = q0;
      a_s[1] = a1; b_s[1] = b1; q_s[1] = q1;
   endtask

   // Drives one cycle; samples IN_READY before the edge and advances the model at the edge.
   task automatic step(input bit c, input bit m, input bit iv, input bit ordy);
      int unsigned s;
      clr = c; mode = m; in_valid = iv; out_ready = ordy;
      #1;
      obs_rdy = in_ready;
      exp_rdy = !c && (!mv || ordy);
      @(posedge clk);
      if (c) begin
         model_init();
      end else if (iv && exp_rdy) begin
         for (int k = 0; k < 2; k++) begin
            s = {24'h0, (a_s[k] | b_s[k])} | ((mx[k] + my[k] - q_s[k]) & 32'hFFFF);
            mz[k] = s[7:0];
            mx[k] = (m ? (mx[k] + q_s[k]) : (mx[k] - q_s[k])) & 32'hFFFF;
            my[k] = (my[k] + 1) & 32'hFFFF;
         end
         mv = 1'b1;
         mb = (mb + 1) & 32'hFFFF;
      end else if (mv && ordy) begin
         mv = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr = 0; mode = 0; in_valid = 0; out_ready = 1;
      set_ops(8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04);
      model_init();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || beats !== 16'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b beats=%h ready=%b want 0 0000 1",
                  out_valid, beats, in_ready);
      end
      for (int c = 0; c < 2; c++) begin
         n_tests++;
         if (z_s[c] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_z ch%0d: got %h want 00", c, z_s[c]);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] want [2];
      do_reset();
      for (int t = 0; t < 2; t++) begin
         want[0] = (t == 0) ? 8'h23 : 8'h1F;
         step(0, 0, 1, 1);
         for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (z_s[c] !== want[0] || z_s[c] !== mz[c]) begin
               n_fail++;
               $display("FAIL basic_z beat%0d ch%0d: got %h want %h", t, c, z_s[c], want[0]);
            end
         end
         n_tests++;
         if (out_valid !== 1'b1 || beats !== 16'(t + 1)) begin
            n_fail++;
            $display("FAIL basic_flags beat%0d: valid=%b beats=%h want 1 %0d",
                     t, out_valid, beats, t + 1);
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] held [2];
      do_reset();
      step(0, 0, 1, 0);
      held = z_s;
      for (int t = 0; t < 5; t++) begin
         step(0, 0, 1, 0);
         n_tests++;
         if (obs_rdy !== 1'b0 || out_valid !== 1'b1 || beats !== 16'd1 ||
             z_s[0] !== held[0] || z_s[1] !== held[1] || held[0] !== 8'h23) begin
            n_fail++;
            $display("FAIL stall_hold cyc%0d: ready=%b valid=%b beats=%h z0=%h want 0 1 0001 23",
                     t, obs_rdy, out_valid, beats, z_s[0]);
         end
      end
      step(0, 0, 1, 1);
      n_tests++;
      if (obs_rdy !== 1'b1 || beats !== 16'd2 || out_valid !== 1'b1 ||
          z_s[0] !== 8'h1F || z_s[1] !== mz[1]) begin
         n_fail++;
         $display("FAIL stall_release: ready=%b beats=%h z0=%h want 1 0002 1f",
                  obs_rdy, beats, z_s[0]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      set_ops(8'h01, 8'h02, 8'h30, 8'h01, 8'h02, 8'h30);
      step(0, 0, 1, 1);
      n_tests++;
      if (z_s[0] !== 8'hF7 || z_s[1] !== 8'hF7) begin
         n_fail++;
         $display("FAIL wrap_mode0: z0=%h z1=%h want f7 f7", z_s[0], z_s[1]);
      end
      do_reset();
      set_ops(8'h01, 8'h02, 8'h30, 8'h01, 8'h02, 8'h30);
      step(0, 1, 1, 1);
      n_tests++;
      if (z_s[0] !== 8'hF7) begin
         n_fail++;
         $display("FAIL wrap_mode1_first: z0=%h want f7", z_s[0]);
      end
      // Second beat exposes X=0x41 from the increment path.
      step(0, 1, 1, 1);
      n_tests++;
      if (z_s[0] !== mz[0] || z_s[0] !== 8'h27) begin
         n_fail++;
         $display("FAIL wrap_mode1_second: z0=%h want 27", z_s[0]);
      end
   endtask

   task automatic test_channels();
      do_reset();
      set_ops(8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h30);
      step(0, 0, 1, 1);
      n_tests++;
      if (z_s[0] !== 8'h23 || z_s[1] !== 8'hF7) begin
         n_fail++;
         $display("FAIL channels: z0=%h z1=%h want 23 f7", z_s[0], z_s[1]);
      end
   endtask

   task automatic test_clear();
      do_reset();
      step(0, 0, 1, 0);
      step(1, 0, 1, 0);
      n_tests++;
      if (obs_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_ready: got %b want 0", obs_rdy);
      end
      n_tests++;
      if (out_valid !== 1'b0 || beats !== 16'h0 || z_s[0] !== 8'h00) begin
         n_fail++;
         $display("FAIL clear_state: valid=%b beats=%h z0=%h want 0 0000 00",
                  out_valid, beats, z_s[0]);
      end
      step(0, 0, 1, 1);
      n_tests++;
      if (z_s[0] !== 8'h23 || z_s[1] !== 8'h23 || beats !== 16'd1) begin
         n_fail++;
         $display("FAIL clear_next: z0=%h z1=%h beats=%h want 23 23 0001", z_s[0], z_s[1], beats);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || beats !== 16'h0 || z_s[0] !== 8'h00 || z_s[1] !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b beats=%h z0=%h want 0 0000 00",
                  out_valid, beats, z_s[0]);
      end
      model_init();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 0, 1, 1);
      n_tests++;
      if (z_s[0] !== 8'h23 || beats !== 16'd1) begin
         n_fail++;
         $display("FAIL async_post: z0=%h beats=%h want 23 0001", z_s[0], beats);
      end
   endtask

   task automatic test_beats_wrap();
      do_reset();
      for (int t = 0; t < 65535; t++) step(0, 0, 1, 1);
      n_tests++;
      if (beats !== 16'hFFFF || beats !== 16'(mb)) begin
         n_fail++;
         $display("FAIL beats_max: got %h want ffff", beats);
      end
      step(0, 0, 1, 1);
      n_tests++;
      if (beats !== 16'h0000) begin
         n_fail++;
         $display("FAIL beats_wrap: got %h want 0000", beats);
      end
   endtask

   task automatic test_random();
      bit c, m, iv, ordy;
      int bad = 0;
      do_reset();
      for (int t = 0; t < 400; t++) begin
         set_ops(8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom));
         c    = ($urandom_range(0, 19) == 0);
         m    = 1'($urandom);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         step(c, m, iv, ordy);
         if (obs_rdy !== exp_rdy || out_valid !== mv || beats !== 16'(mb) ||
             z_s[0] !== mz[0] || z_s[1] !== mz[1]) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random cyc%0d: rdy=%b v=%b beats=%h z=%h,%h want %b %b %h %h,%h",
                        t, obs_rdy, out_valid, beats, z_s[0], z_s[1],
                        exp_rdy, mv, 16'(mb), mz[0], mz[1]);
         end
      end
      n_tests++;
      if (bad != 0) n_fail++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_channels();
      test_clear();
      test_async_reset();
      test_random();
      test_beats_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
